// File: rtl/gamepad_reader.sv
// gamepad_reader: polls an NES-style 8-button shift-register pad once per
// poll period. Decoded buttons are held as registered levels between reads.
// The move and aim lines have opposite-direction conflicts removed.
module gamepad_reader #(
    parameter int HALF        = 6,
    parameter int POLL_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic       move_left,
    output logic       move_right,
    output logic       aim_left,
    output logic       aim_right,
    output logic       shoot,
    output logic       start_new_game,
    output logic       valid
);

    localparam int PC_W  = $clog2(POLL_CYCLES);
    localparam int CNT_W = $clog2(2 * HALF);

    localparam logic [PC_W-1:0]  PC_LAST    = PC_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LO,
        HI,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       sync;
    logic             pressed;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic [2:0]       k;
    logic [7:0]       shift;
    logic             pc_wrap;

    // The pad is active-low, so 1 means pressed after inversion.
    assign pressed = ~sync[1];
    assign pc_wrap = (pc == PC_LAST);

    // Two-flop synchronizer. It resets to the released (high) level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], pad_data};
        end
    end

    // Free-running poll counter. It keeps counting through a read, so latch
    // edges are exactly POLL_CYCLES apart. Reset preloads it to the wrap
    // value so the first edge after reset starts a read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= PC_LAST;
        end else if (pc_wrap) begin
            pc <= '0;
        end else begin
            pc <= pc + PC_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The latch phase is two half-periods long. LO and HI are one half-period each.
    always_comb begin
        cnt_last = 1'b0;
        if (state == LATCH) begin
            cnt_last = (cnt == LATCH_LAST);
        end else begin
            cnt_last = (cnt == HALF_LAST);
        end
    end

    // Next-state logic for the latch / clock-low / clock-high sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pc_wrap) next_state = LATCH;
            LATCH:   if (cnt_last) next_state = LO;
            LO:      if (cnt_last) next_state = (k == 3'd7) ? DONE : HI;
            HI:      if (cnt_last) next_state = LO;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Phase counter. It restarts on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state != next_state) begin
            cnt <= '0;
        end else if (state == LATCH || state == LO || state == HI) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Bit index. It is cleared during the latch and advanced at the end of each HI phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k <= 3'd0;
        end else if (state == LATCH) begin
            k <= 3'd0;
        end else if (state == HI && cnt_last) begin
            k <= k + 3'd1;
        end
    end

    // Capture each bit on the last cycle of its LO phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift <= 8'h00;
        end else if (state == LO && cnt_last) begin
            shift[k] <= pressed;
        end
    end

    // Pad pins are registered from the next state, so they follow the state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
        end else begin
            pad_latch <= (next_state == LATCH);
            pad_clk   <= (next_state == HI);
        end
    end

    // Publish a complete frame in one edge. Opposing directions cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buttons        <= 8'h00;
            move_left      <= 1'b0;
            move_right     <= 1'b0;
            aim_left       <= 1'b0;
            aim_right      <= 1'b0;
            shoot          <= 1'b0;
            start_new_game <= 1'b0;
            valid          <= 1'b0;
        end else begin
            valid <= (state == DONE);
            if (state == DONE) begin
                buttons        <= shift;
                move_left      <= shift[6] & ~shift[7];
                move_right     <= shift[7] & ~shift[6];
                aim_left       <= shift[4] & ~shift[5];
                aim_right      <= shift[5] & ~shift[4];
                shoot          <= shift[0];
                start_new_game <= shift[3];
            end
        end
    end

endmodule

// File: doc/gamepad_reader.md
# gamepad_reader

Serial game-pad front end that polls an 8-button shift-register controller (NES-style latch/clock/data protocol) and drives the level-style button lines consumed by the `controls` block. It owns the pad pins, sequences one read per poll period and holds the decoded buttons as registered levels between reads. It resolves opposite-direction conflicts before they reach `controls`. It does not filter multi-button presses; `controls` already rejects those.

## Interface
- `HALF`, default 6: half-period of `pad_clk` in `clk` cycles. Minimum 3.
- `POLL_CYCLES`, default 4096: cycles between successive `pad_latch` rising edges. Minimum 17*HALF+2.
- `clk` input 1: system clock. All logic is on its rising edge.
- `reset` input 1: reset, asynchronous and active-low.
- `pad_data` input 1: serial data from the pad. Active-low, so 0 means pressed.
- `pad_latch` output 1: parallel-load strobe to the pad. Active-high.
- `pad_clk` output 1: shift clock to the pad. The pad shifts on its rising edge.
- `buttons` output 8: raw pressed flags, 1 means pressed. Bit order is {Right, Left, Down, Up, Start, Select, B, A}, with A at bit 0.
- `move_left`, `move_right` output 1: Left and Right after conflict filtering.
- `aim_left`, `aim_right` output 1: Up and Down after conflict filtering.
- `shoot` output 1: A.
- `start_new_game` output 1: Start.
- `valid` output 1: one-cycle pulse when the outputs have just been updated.

## Operation
- `pad_data` passes through a 2-flop synchronizer. All sampling uses the synchronized value, inverted to give 1 = pressed.
- States: IDLE, LATCH, LO, HI, DONE.
- IDLE:
  - `pad_latch`=0 and `pad_clk`=0.
  - Free-running poll counter `pc`. When `pc` = POLL_CYCLES-1: clear `pc`, enter LATCH.
- LATCH: `pad_latch`=1 for 2*HALF cycles, then enter LO with bit index k=0.
- LO:
  - `pad_clk`=0 for HALF cycles.
  - On the last cycle, capture the synchronized bit into shift bit k.
  - If k<7, enter HI. If k=7, enter DONE.
- HI: `pad_clk`=1 for HALF cycles, then k=k+1 and enter LO.
- DONE, one cycle:
  - Load all outputs from the 8 captured bits in the same edge.
  - Pulse `valid`.
  - Return to IDLE.
- `pc` keeps counting through the whole read, so `pad_latch` rising edges are exactly POLL_CYCLES apart.
- Conflict filter:
  - If Left and Right are both pressed, `move_left` and `move_right` are both 0.
  - If Up and Down are both pressed, `aim_left` and `aim_right` are both 0.
  - `buttons` is always unfiltered.
- All outputs hold their values between DONE cycles. Partial reads never reach the outputs.
- Unplugged pad:
  - `pad_data` held high reads all-released.
  - `pad_data` held low reads `buttons`=8'hFF, with all move and aim outputs 0 because of the filter.
- `pad_latch`, `pad_clk` and all outputs are driven from registers.

## Timing
- Reset asserted:
  - All outputs are 0, including `pad_latch`, `pad_clk`, `buttons` and `valid`.
  - State is IDLE, with `pc`=POLL_CYCLES-1, k=0, and the synchronizer cleared to the released level.
- Reset release: the first rising edge enters LATCH. Call this edge E0.
- Frame timing, relative to E0:
  - `pad_latch` is high for edges E0 to E0+2H-1.
  - Bit k is captured at edge E0+3H+2Hk, so A at E0+3H and Right at E0+17H.
  - `pad_clk` rises at E0+3H+2Hk for k=0..6, giving 7 pulses, each H cycles high.
  - Outputs and `valid` update at edge E0+17H+1.
  - The next LATCH starts at E0+POLL_CYCLES.
- Data arriving after a `pad_clk` rise is not seen by the sample taken at that same edge, because of the 2-flop delay.
- Reset mid-read: the read is abandoned and everything returns to its reset values immediately. The old outputs are not preserved.
- `pad_data` glitches outside the sample edges have no effect.

## Test plan
Parameters for all scenarios: HALF=4, POLL_CYCLES=100. The pad model shifts on `pad_clk` rise.

1. Reset, then release:
   - `pad_latch` is high for 8 cycles starting at the first edge.
   - Exactly 7 `pad_clk` pulses, each 4 cycles high.
   - `valid` is high exactly at cycle 69 after E0.
   - Next `pad_latch` rise at cycle 100.
2. Pad presents Left+A (`buttons`=8'h41):
   - `buttons`=8'h41, `move_left`=1, `shoot`=1, all other outputs 0.
   - All outputs are stable until the next `valid`.
3. Pad presents Left+Right+Up (8'hD0):
   - `buttons`=8'hD0, `move_left`=0, `move_right`=0, `aim_left`=1.
4. Pad presents Start only (8'h08) for one frame, then 8'h00:
   - `start_new_game`=1 for exactly one poll period, then 0 after the next `valid`.
5. `pad_data` tied low:
   - `buttons`=8'hFF, `shoot`=1, `start_new_game`=1, all move and aim outputs 0.
   - With `pad_data` tied high instead: all outputs 0 and `valid` still pulses every 100 cycles.
6. Reset asserted at cycle 30 of a read, with the previous `buttons`=8'h41:
   - Outputs go to 0 asynchronously with no `valid` pulse.
   - After release, a fresh LATCH starts on the first edge.
